seq_comparator: RTL and testbench

SEQ_COMPARATOR -- requirements
Module: seq_comparator

---
 rtl/seq_comparator.sv | 134 +++++++++++++
 tb/tb_seq_comparator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude comparator, one CHUNK-bit slice per
// cycle, MSB slice first, with early exit on the first unequal slice.
// Signed compares flip the sign bit of both operands at capture time so the
// slice datapath is always unsigned.
module seq_comparator #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHUNK     = 2,
   parameter int unsigned SIGNED_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               busy_nxt;
   logic               done_nxt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [IDX_W-1:0]   idx;
   logic [CHUNK-1:0]   slice_a;
   logic [CHUNK-1:0]   slice_b;
   logic               slice_ne;
   logic               last_chunk;
   logic               eff_signed;
   logic [WIDTH-1:0]   flip;

   // Effective mode: signed only when the parameter allows it.
   assign eff_signed = (SIGNED_EN != 0) && signed_mode;
   assign flip       = eff_signed ? MSB_MASK : '0;
   assign slice_ne   = (slice_a != slice_b);
   assign last_chunk = (idx == LAST_IDX);

   // Select the slice addressed by the chunk index (index 0 = MSB slice).
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < int'(NCHUNK); i++) begin
         if (idx == IDX_W'(i)) begin
            slice_a = a_q[int'(WIDTH) - 1 - i * int'(CHUNK) -: CHUNK];
            slice_b = b_q[int'(WIDTH) - 1 - i * int'(CHUNK) -: CHUNK];
         end
      end
   end

   // State register; busy/done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CMP;
         CMP:  if (slice_ne || last_chunk) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode feeding the busy/done registers.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      if (state_nxt != IDLE) busy_nxt = 1'b1;
      if (state_nxt == DONE) done_nxt = 1'b1;
   end

   // Operand capture, chunk index walk and result update.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         idx <= '0;
         eq  <= 1'b0;
         gt  <= 1'b0;
         lt  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q <= a ^ flip;
                  b_q <= b ^ flip;
                  idx <= '0;
               end
            end
            CMP: begin
               if (slice_ne) begin
                  eq <= 1'b0;
                  gt <= (slice_a > slice_b);
                  lt <= (slice_a < slice_b);
               end else if (last_chunk) begin
                  eq <= 1'b1;
                  gt <= 1'b0;
                  lt <= 1'b0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: 8-bit/2-bit-chunk instance with randomized and
// directed compares against an arithmetic reference, plus an exhaustive
// 2-bit unsigned-only instance.
module tb_seq_comparator;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       signed_mode;
   logic       busy, done, eq, gt, lt;

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       signed_mode2;
   logic       busy2, done2, eq2, gt2, lt2;

   int vectors;
   int miscompares;
   logic [2:0] prev_res;   // expected {eq,gt,lt} held from last completion

   seq_comparator #(.WIDTH(8), .CHUNK(2), .SIGNED_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .signed_mode(signed_mode), .busy(busy), .done(done),
      .eq(eq), .gt(gt), .lt(lt)
   );

   seq_comparator #(.WIDTH(2), .CHUNK(2), .SIGNED_EN(0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .signed_mode(signed_mode2), .busy(busy2), .done(done2),
      .eq(eq2), .gt(gt2), .lt(lt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: relation from integer arithmetic; latency from the position
   // of the most significant differing bit (2-bit chunks, 4 chunks).
   function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                 input logic sm, output logic [2:0] res,
                                 output int k);
      int  sx, sy;
      bit  found;
      if (sm) begin
         sx = int'($signed(x));
         sy = int'($signed(y));
      end else begin
         sx = int'(x);
         sy = int'(y);
      end
      res   = {sx == sy, sx > sy, sx < sy};
      k     = 4;
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (!found && x[i] != y[i]) begin
            k     = (7 - i) / 2 + 1;
            found = 1'b1;
         end
      end
   endfunction

   // One compare on the 8-bit instance; inputs are scrambled while busy.
   task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tsm, input string name);
      logic [2:0] exp_res;
      int         exp_k;
      int         n;
      model(ta, tb_v, tsm, exp_res, exp_k);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s idle_busy: got %b expected 0", name, busy);
      end
      start = 1'b1; a = ta; b = tb_v; signed_mode = tsm;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 20) begin
         vectors++;
         if (busy !== 1'b1 || {eq, gt, lt} !== prev_res) begin
            miscompares++;
            $display("FAIL %s hold: busy=%b res=%b expected busy=1 res=%b",
                     name, busy, {eq, gt, lt}, prev_res);
         end
         start = 1'($urandom_range(0, 1));
         a = 8'($urandom);
         b = 8'($urandom);
         signed_mode = 1'($urandom_range(0, 1));
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      vectors++;
      if (n != exp_k || busy !== 1'b1 || {eq, gt, lt} !== exp_res) begin
         miscompares++;
         $display("FAIL %s result: a=%h b=%h s=%b latency=%0d busy=%b res=%b expected latency=%0d busy=1 res=%b",
                  name, ta, tb_v, tsm, n, busy, {eq, gt, lt}, exp_k, exp_res);
      end
      prev_res = exp_res;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0; a2 = '0; b2 = '0; signed_mode2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, eq, gt, lt} !== 5'b0 || {busy2, done2, eq2, gt2, lt2} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_state: got %b/%b expected 00000/00000",
                  {busy, done, eq, gt, lt}, {busy2, done2, eq2, gt2, lt2});
      end
      rst = 1'b0;
      prev_res = 3'b000;
   endtask

   task automatic test_directed();
      run_cmp(8'hA5, 8'hA5, 1'b0, "eq_a5");
      run_cmp(8'h80, 8'h7F, 1'b0, "early_unsigned");
      run_cmp(8'h80, 8'h7F, 1'b1, "early_signed");
      run_cmp(8'h40, 8'h41, 1'b0, "ignore_start");
      run_cmp(8'hFF, 8'h00, 1'b1, "signed_neg1_vs_0");
      run_cmp(8'h7F, 8'h7F, 1'b1, "signed_eq");
   endtask

   task automatic test_back_to_back();
      run_cmp(8'h12, 8'h13, 1'b0, "b2b_first");
      run_cmp(8'h13, 8'h12, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      logic [7:0] x, y;
      for (int t = 0; t < 60; t++) begin
         x = 8'($urandom);
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = x ^ (8'(1) << $urandom_range(0, 7));
            default: y = 8'($urandom);
         endcase
         run_cmp(x, y, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02; signed_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, eq, gt, lt} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_abort: got %b expected 00000", {busy, done, eq, gt, lt});
      end
      rst = 1'b0;
      prev_res = 3'b000;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: cycle %0d done=%b busy=%b expected 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_exhaustive_w2();
      logic [2:0] exp_res;
      for (int x = 0; x < 4; x++) begin
         for (int y = 0; y < 4; y++) begin
            exp_res = {x == y, x > y, x < y};
            @(negedge clk);
            start2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
            signed_mode2 = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            vectors++;
            if (done2 !== 1'b0 || busy2 !== 1'b1) begin
               miscompares++;
               $display("FAIL w2_cmp_cycle: a=%0d b=%0d done=%b busy=%b expected 0 1", x, y, done2, busy2);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (done2 !== 1'b1 || {eq2, gt2, lt2} !== exp_res) begin
               miscompares++;
               $display("FAIL w2_result: a=%0d b=%0d done=%b res=%b expected 1 %b",
                        x, y, done2, {eq2, gt2, lt2}, exp_res);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      prev_res    = 3'b000;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_abort();
      test_exhaustive_w2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
